serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Sequencer for a bit-serial full adder. Accepts a pair of WIDTH-bit operands over a valid/ready handshake. Shifts the operands LSB-first through a 1-bit carry-state adder, one bit per clock, and assembles the sum. Returns the sum and the carry-out over a second valid/ready handshake. It sits between a host or bus agent and the serial adder datapath, and holds that datapath busy for exactly WIDTH cycles per operation.

Parameters:
WIDTH, 8, operand and sum width in bits. Legal range is 2..32.

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand pair a/b is presented
in_ready  out  1  controller can accept operands (IDLE only)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  sum/cout are valid (DONE only)
out_ready  in  1  consumer accepts the result
sum  out  WIDTH  a+b modulo 2^WIDTH
cout  out  1  carry out of bit WIDTH-1
busy  out  1  high in RUN or DONE
bit_idx  out  clog2(WIDTH)  index of the bit being added in RUN; 0 otherwise

Behaviour:
- One clock domain; reset is synchronous and active-high; all state updates on posedge clk.
- Reset state:
  - state=IDLE; internal carry=0; counter=0; a/b shift registers=0.
  - Outputs: sum=0, cout=0, out_valid=0, busy=0, bit_idx=0, in_ready=1.
- States:
  - IDLE: in_ready=1.
    - At an edge with in_valid=1: latch a and b into shift registers, clear carry, clear counter, go to RUN.
    - in_valid=0: stay in IDLE.
  - RUN: in_ready=0, busy=1, bit_idx=counter.
    - Each edge computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
    - On that edge: carry<=c; sum register <= {s, sum[WIDTH-1:1]}; a_sr and b_sr shift right by 1; counter++.
    - At the edge where counter==WIDTH-1: cout<=c, go to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0. sum and cout are held stable.
    - At an edge with out_ready=1: go to IDLE.
    - out_ready=0: stay in DONE indefinitely.
- Latency and throughput:
  - Operands are accepted at edge E0.
  - RUN occupies edges E1..E_WIDTH; out_valid rises after edge E_WIDTH.
  - Minimum spacing between accepts is WIDTH+2 cycles: accept, WIDTH RUN cycles, and one DONE cycle with out_ready=1.
- sum and cout keep their last values after returning to IDLE, but are meaningful only while out_valid=1. The sum register is not cleared at accept.
- in_valid during RUN or DONE is ignored. Operands are not captured and the upstream must hold them.
- Changes on a/b after accept have no effect on the current operation.
- out_ready while not in DONE has no effect.
- Reset asserted in any state, including mid-RUN, returns to the reset state on that edge. The partial result is discarded and no out_valid pulse is produced.
- Arithmetic is unsigned; overflow is reported only through cout.

Test Plan:
1. Reset, then a=8'h5A, b=8'h3C with in_valid for 1 cycle, out_ready=1. Required: out_valid rises exactly 8 clocks after the accept edge, sum=8'h96, cout=0, and in_ready returns high 1 cycle after the result handshake.
2. a=8'hFF, b=8'h01. Required: sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF. Required: sum=8'hFE, cout=1, proving carry is cleared between operations.
3. Backpressure: a=8'h12, b=8'h34, out_ready held low 5 cycles after out_valid rises. Required: out_valid stays 1 with sum=8'h46 stable all 5 cycles; IDLE is entered only on the edge where out_ready=1.
4. During RUN, drive in_valid=1 with a=8'hAA, b=8'h55. Required: in_ready=0 and the ongoing result is unchanged. The new pair is accepted only after the return to IDLE, giving sum=8'hFF, cout=0.
5. Accept a=8'h80, b=8'h80, then assert reset when bit_idx==3. Required: next cycle state=IDLE, busy=0, out_valid=0, in_ready=1, cout=0. A subsequent 8'h01+8'h02 gives 8'h03.
6. Check bit_idx over one operation. Required: it counts 0..7 across the 8 RUN cycles, and busy is high from the cycle after accept until the result handshake.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial full adder: accepts an operand pair, adds one bit per clock
// LSB-first through a single carry flop, and returns sum/cout over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | adding bit bit_idx, WIDTH cycles
//   DONE  | result held on sum/cout until out_ready
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    localparam int IW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [IW-1:0]    bit_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    state_t           state;
    logic             carry;
    logic [IW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             s_bit;
    logic             c_bit;

    always_comb begin
        s_bit = a_sr[0] ^ b_sr[0] ^ carry;
        c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // cnt is returned to 0 on leaving RUN, so it doubles as bit_idx in every state
    assign bit_idx = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry    <= 1'b0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    carry <= c_bit;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    if (cnt == LAST) begin
                        cout      <= c_bit;
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a cycle-accurate transaction model checked every cycle,
// plus literal expectations for each directed operation.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic [2:0]   bit_idx;

    int vectors = 0;
    int fails   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_cnt = -1 idle, 0..W-1 cycles into the add, W = result waiting
    int           m_cnt = -1;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always begin
        @(posedge clk);
        if (reset) begin
            m_cnt  = -1;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_cnt < 0) begin
            if (in_valid) begin
                m_cnt  = 0;
                m_pend = {1'b0, a} + {1'b0, b};
            end
        end else if (m_cnt < W) begin
            m_cnt++;
            if (m_cnt == W) begin
                m_sum  = m_pend[W-1:0];
                m_cout = m_pend[W];
            end
        end else if (out_ready) begin
            m_cnt = -1;
        end
        #1;
        chk("in_ready", int'(in_ready), int'(m_cnt < 0));
        chk("busy", int'(busy), int'(m_cnt >= 0));
        chk("out_valid", int'(out_valid), int'(m_cnt == W));
        chk("bit_idx", int'(bit_idx), (m_cnt >= 0 && m_cnt < W) ? m_cnt : 0);
        chk("cout", int'(cout), int'(m_cout));
        if (m_cnt < 0 || m_cnt == W)
            chk("sum", int'(sum), int'(m_sum));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Waits for out_valid after an accept edge; returns edges taken, bounded
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold,
                          input logic [W-1:0] es, input logic ec, input string tag);
        int lat;
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        wait_result(lat);
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_sum"}, int'(sum), int'(es));
        chk({tag, "_cout"}, int'(cout), int'(ec));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_sum"}, int'(sum), int'(es));
        end
        out_ready = 1'b1;
        step();
        chk({tag, "_in_ready_after"}, int'(in_ready), 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int lat;
        int n;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        reset = 1'b0;
        step();

        run_op(8'h5A, 8'h3C, 0, 8'h96, 1'b0, "t1");
        run_op(8'hFF, 8'h01, 0, 8'h00, 1'b1, "t2a");
        run_op(8'hFF, 8'hFF, 0, 8'hFE, 1'b1, "t2b");
        run_op(8'h12, 8'h34, 5, 8'h46, 1'b0, "t3");

        // in_valid held through RUN/DONE with a new pair must not disturb the current add
        a = 8'h0F;
        b = 8'h01;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        a = 8'hAA;
        b = 8'h55;
        step();
        chk("t4_in_ready_run", int'(in_ready), 0);
        wait_result(lat);
        chk("t4_first_sum", int'(sum), 8'h10);
        chk("t4_first_cout", int'(cout), 0);
        step();
        chk("t4_in_ready_idle", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("t4_second_busy", int'(busy), 1);
        wait_result(lat);
        chk("t4_second_lat", lat, W);
        chk("t4_second_sum", int'(sum), 8'hFF);
        chk("t4_second_cout", int'(cout), 0);
        step();

        // reset in the middle of an add
        a = 8'h80;
        b = 8'h80;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (bit_idx != 3'd3 && n < 20) begin
            step();
            n++;
        end
        chk("t5_reach_idx3", int'(bit_idx), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        chk("t5_cout", int'(cout), 0);
        chk("t5_bit_idx", int'(bit_idx), 0);
        step();
        run_op(8'h01, 8'h02, 0, 8'h03, 1'b0, "t5b");

        // bit_idx walk
        a = 8'h33;
        b = 8'h11;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("t6_bit_idx", int'(bit_idx), k);
            chk("t6_busy", int'(busy), 1);
            step();
        end
        chk("t6_out_valid", int'(out_valid), 1);
        chk("t6_sum", int'(sum), 8'h44);
        chk("t6_busy_done", int'(busy), 1);
        out_ready = 1'b1;
        step();
        chk("t6_busy_idle", int'(busy), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
